// File: rtl/led_bank_arbiter.sv
// rtl/led_bank_arbiter.sv - round-robin arbiter sharing an LED bank, gray-code idle pattern
module led_bank_arbiter #(
    parameter int N_REQ     = 4,
    parameter int N_LED     = 5,
    parameter int LOG2DELAY = 22,
    parameter int MAX_HOLD  = 1024
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         rel,
    input  logic [N_REQ*N_LED-1:0]   pat,
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic [N_LED-1:0]         leds,
    output logic                     timeout
);
    localparam int CW = N_LED + LOG2DELAY;
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [PW-1:0] OWNER_LAST = PW'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_owner;
    logic [HW-1:0]      r_hold;
    logic [N_REQ-1:0]   r_gnt;
    logic               r_busy;
    logic [N_LED-1:0]   r_leds;
    logic               r_timeout;

    logic               w_found;
    logic [PW-1:0]      w_pick;
    logic [N_REQ-1:0]   w_pick_oh;
    logic [N_LED-1:0]   w_cnt_hi;
    logic [N_LED-1:0]   w_gray;
    logic [N_LED-1:0]   w_own_pat;
    logic               w_rel_own;
    logic               w_req_own;
    logic               w_hold_end;
    logic               w_end;

    // Rotating priority search starting at r_ptr
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_pick  = '0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_pick  = PW'(idx);
            end
        end
    end

    assign w_pick_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
    assign w_cnt_hi   = r_cnt[CW-1 -: N_LED];
    assign w_gray     = w_cnt_hi ^ (w_cnt_hi >> 1);
    assign w_own_pat  = pat[r_owner*N_LED +: N_LED];
    assign w_rel_own  = rel[r_owner];
    assign w_req_own  = req[r_owner];
    assign w_hold_end = (r_hold == HOLD_LAST);
    assign w_end      = w_rel_own || !w_req_own || w_hold_end;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_hold    <= '0;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_leds    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= r_cnt + 1'b1;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_leds <= w_gray;
                    if (w_found) begin
                        r_gnt   <= w_pick_oh;
                        r_owner <= w_pick;
                        r_hold  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_end) begin
                        r_state   <= S_GAP;
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_leds    <= '0;
                        r_ptr     <= (r_owner == OWNER_LAST) ? '0 : r_owner + 1'b1;
                        // A timeout only counts when the owner did not let go on its own
                        r_timeout <= w_hold_end && !w_rel_own && w_req_own;
                    end else begin
                        r_leds <= w_own_pat;
                        r_hold <= r_hold + 1'b1;
                    end
                end
                S_GAP: begin
                    r_leds  <= w_gray;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign leds    = r_leds;
    assign timeout = r_timeout;
endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb/tb_led_bank_arbiter.sv - randomized self-checking bench for led_bank_arbiter
module tb_led_bank_arbiter;
    localparam int N_REQ     = 4;
    localparam int N_LED     = 5;
    localparam int LOG2DELAY = 2;
    localparam int MAX_HOLD  = 8;
    localparam int CNT_MOD   = 1 << (N_LED + LOG2DELAY);

    logic                   clk = 1'b0;
    logic                   resetn = 1'b0;
    logic [N_REQ-1:0]       req = '0;
    logic [N_REQ-1:0]       rel = '0;
    logic [N_REQ*N_LED-1:0] pat = '0;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic [N_LED-1:0]       leds;
    logic                   timeout;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: owner index (-1 = none), gap flag, grant cycles served
    int               m_cnt;
    int               m_owner;
    bit               m_gap;
    int               m_ptr;
    int               m_served;
    logic [N_REQ-1:0] m_gnt;
    logic             m_busy;
    logic [N_LED-1:0] m_leds;
    logic             m_timeout;

    always #5 clk = ~clk;

    led_bank_arbiter #(
        .N_REQ(N_REQ), .N_LED(N_LED), .LOG2DELAY(LOG2DELAY), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk), .resetn(resetn), .req(req), .rel(rel), .pat(pat),
        .gnt(gnt), .busy(busy), .leds(leds), .timeout(timeout)
    );

    task automatic model_reset();
        m_cnt = 0; m_owner = -1; m_gap = 0; m_ptr = 0; m_served = 0;
        m_gnt = '0; m_busy = 0; m_leds = '0; m_timeout = 0;
    endtask

    task automatic model_edge(input logic [N_REQ-1:0] rq, input logic [N_REQ-1:0] rl,
                              input logic [N_REQ*N_LED-1:0] pt);
        int c;
        int g;
        bit by_rel, by_drop, by_to;
        c = (m_cnt >> LOG2DELAY) % (1 << N_LED);
        g = c ^ (c >> 1);
        m_timeout = 0;
        if (m_gap) begin
            m_gap = 0;
            m_leds = N_LED'(g);
        end else if (m_owner < 0) begin
            m_leds = N_LED'(g);
            for (int k = 0; k < N_REQ; k++) begin
                if (m_owner < 0 && rq[(m_ptr + k) % N_REQ]) m_owner = (m_ptr + k) % N_REQ;
            end
            if (m_owner >= 0) begin
                m_served = 0;
                m_gnt = N_REQ'(1 << m_owner);
                m_busy = 1;
            end
        end else begin
            m_served++;
            by_rel  = rl[m_owner];
            by_drop = !rq[m_owner];
            by_to   = (m_served == MAX_HOLD);
            if (by_rel || by_drop || by_to) begin
                m_timeout = by_to && !by_rel && !by_drop;
                m_ptr = (m_owner + 1) % N_REQ;
                m_owner = -1; m_gap = 1;
                m_gnt = '0; m_busy = 0; m_leds = '0;
            end else begin
                m_leds = N_LED'(pt >> (m_owner * N_LED));
            end
        end
        m_cnt = (m_cnt + 1) % CNT_MOD;
    endtask

    task automatic step(input logic [N_REQ-1:0] rq, input logic [N_REQ-1:0] rl,
                        input logic [N_REQ*N_LED-1:0] pt);
        req = rq; rel = rl; pat = pt;
        @(posedge clk);
        model_edge(rq, rl, pt);
        #2;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req = '0; rel = '0;
        model_reset();
        @(posedge clk);
        #2;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #13;
        model_reset();
        n_cmp++;
        if ({gnt, busy, leds, timeout} !== {m_gnt, m_busy, m_leds, m_timeout}) begin
            n_fail++;
            $display("FAIL reset: got gnt=%b busy=%b leds=%h to=%b, expected all zero", gnt, busy, leds, timeout);
        end
        @(posedge clk);
        #2;
        resetn = 1'b1;
    endtask

    task automatic test_idle_pattern();
        int changes;
        logic [N_LED-1:0] prev;
        changes = 0;
        prev = leds;
        for (int i = 0; i < 40; i++) begin
            step('0, 4'($urandom), 20'($urandom));
            n_cmp++;
            if ({gnt, busy, leds, timeout} !== {m_gnt, m_busy, m_leds, m_timeout}) begin
                n_fail++;
                $display("FAIL idle_pattern cyc %0d: got gnt=%b busy=%b leds=%h to=%b, expected gnt=%b busy=%b leds=%h to=%b",
                         i, gnt, busy, leds, timeout, m_gnt, m_busy, m_leds, m_timeout);
            end
            if (leds != prev) changes++;
            prev = leds;
        end
        n_cmp++;
        if (changes != 9) begin
            n_fail++;
            $display("FAIL idle_step_count: got %0d changes, expected 9", changes);
        end
    endtask

    task automatic test_release();
        do_reset();
        step(4'b0110, '0, 20'($urandom));
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL first_pick: got gnt=%b, expected 0010", gnt);
        end
        step(4'b0110, '0, 20'($urandom));
        step(4'b0110, '0, 20'($urandom));
        step(4'b0110, 4'b1111, 20'($urandom));
        n_cmp++;
        if ({gnt, busy, leds, timeout} !== {4'b0000, 1'b0, 5'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL release_gap: got gnt=%b busy=%b leds=%h to=%b, expected 0000 0 00 0", gnt, busy, leds, timeout);
        end
        step(4'b0110, '0, 20'($urandom));
        step(4'b0110, '0, 20'($urandom));
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL next_owner: got gnt=%b, expected 0100", gnt);
        end
        n_cmp++;
        if ({gnt, busy, leds, timeout} !== {m_gnt, m_busy, m_leds, m_timeout}) begin
            n_fail++;
            $display("FAIL release_model: got gnt=%b busy=%b leds=%h to=%b, expected gnt=%b busy=%b leds=%h to=%b",
                     gnt, busy, leds, timeout, m_gnt, m_busy, m_leds, m_timeout);
        end
    endtask

    task automatic test_timeout();
        logic [N_REQ*N_LED-1:0] pt;
        do_reset();
        for (int i = 1; i <= 24; i++) begin
            pt = 20'($urandom);
            pt[4:0] = 5'h15;
            step(4'b0001, 4'($urandom) & 4'b1110, pt);
            n_cmp++;
            if ({gnt, busy, leds, timeout} !== {m_gnt, m_busy, m_leds, m_timeout}) begin
                n_fail++;
                $display("FAIL timeout_model cyc %0d: got gnt=%b busy=%b leds=%h to=%b, expected gnt=%b busy=%b leds=%h to=%b",
                         i, gnt, busy, leds, timeout, m_gnt, m_busy, m_leds, m_timeout);
            end
            if (i == 2 && leds !== 5'h15) begin
                n_fail++;
                $display("FAIL owner_leds: got %h, expected 15", leds);
            end
            if (i == 9 && timeout !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_pulse: got %b, expected 1", timeout);
            end
            if (i == 11 && gnt !== 4'b0001) begin
                n_fail++;
                $display("FAIL regrant: got gnt=%b, expected 0001", gnt);
            end
        end
        n_cmp += 3;
    endtask

    task automatic test_rel_at_max();
        int guard;
        do_reset();
        guard = 0;
        while (!(m_owner == 0 && m_served == MAX_HOLD - 1) && guard < 50) begin
            step(4'b0001, '0, 20'($urandom));
            guard++;
        end
        step(4'b0001, 4'b0001, 20'($urandom));
        n_cmp++;
        if ({gnt, busy, leds, timeout} !== {4'b0000, 1'b0, 5'h00, 1'b0} || guard >= 50) begin
            n_fail++;
            $display("FAIL rel_at_max: got gnt=%b busy=%b leds=%h to=%b guard=%0d, expected 0000 0 00 0",
                     gnt, busy, leds, timeout, guard);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        step(4'b0100, '0, 20'($urandom));
        step(4'b0100, '0, 20'h0ffff);
        step(4'b0100, '0, 20'h0ffff);
        #1;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({gnt, busy, leds, timeout} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got gnt=%b busy=%b leds=%h to=%b, expected all zero", gnt, busy, leds, timeout);
        end
        model_reset();
        @(posedge clk);
        #2;
        resetn = 1'b1;
        step(4'b1111, '0, 20'($urandom));
        n_cmp++;
        if (gnt !== 4'b0001 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_pick: got gnt=%b to=%b, expected 0001 0", gnt, timeout);
        end
    endtask

    task automatic test_all_hold();
        int wait_cnt [N_REQ];
        int max_wait;
        int order [$];
        logic [N_REQ-1:0] prev_gnt;
        do_reset();
        max_wait = 0;
        prev_gnt = '0;
        for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;
        for (int i = 0; i < 100; i++) begin
            step(4'b1111, '0, 20'($urandom));
            n_cmp++;
            if ({gnt, busy, leds, timeout} !== {m_gnt, m_busy, m_leds, m_timeout}) begin
                n_fail++;
                $display("FAIL all_hold cyc %0d: got gnt=%b busy=%b leds=%h to=%b, expected gnt=%b busy=%b leds=%h to=%b",
                         i, gnt, busy, leds, timeout, m_gnt, m_busy, m_leds, m_timeout);
            end
            if (prev_gnt == '0 && gnt != '0) begin
                for (int r = 0; r < N_REQ; r++) if (gnt[r]) order.push_back(r);
            end
            prev_gnt = gnt;
            for (int r = 0; r < N_REQ; r++) begin
                wait_cnt[r] = gnt[r] ? 0 : wait_cnt[r] + 1;
                if (wait_cnt[r] > max_wait) max_wait = wait_cnt[r];
            end
        end
        n_cmp++;
        if (order.size() < 5 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3 || order[4] != 0) begin
            n_fail++;
            $display("FAIL rotation: got %0d grants starting %p, expected 0,1,2,3,0", order.size(), order);
        end
        n_cmp++;
        if (max_wait > 42) begin
            n_fail++;
            $display("FAIL max_wait: got %0d, expected <= 42", max_wait);
        end
    endtask

    task automatic test_random();
        logic [N_REQ-1:0] rq;
        logic [N_REQ-1:0] rl;
        rq = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            rl = ($urandom_range(0, 5) == 0) ? 4'($urandom) : '0;
            step(rq, rl, 20'($urandom));
            n_cmp++;
            if ({gnt, busy, leds, timeout} !== {m_gnt, m_busy, m_leds, m_timeout}) begin
                n_fail++;
                $display("FAIL random cyc %0d: got gnt=%b busy=%b leds=%h to=%b, expected gnt=%b busy=%b leds=%h to=%b",
                         i, gnt, busy, leds, timeout, m_gnt, m_busy, m_leds, m_timeout);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_pattern();
        test_release();
        test_timeout();
        test_rel_at_max();
        test_reset_mid_grant();
        test_all_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/led_bank_arbiter.md
LED_BANK_ARBITER -- requirements
Module: led_bank_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the LED bank (2..8).
REQ-002 Parameter N_LED, default 5, LED bank width.
REQ-003 Parameter LOG2DELAY, default 22, idle-pattern step period is 2^LOG2DELAY clk cycles.
REQ-004 Parameter MAX_HOLD, default 1024, grant timeout in cycles (>=2).
REQ-005 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 Port resetn  input  1  reset, asynchronous and active-low.
REQ-007 Port req  input  N_REQ  level request, bit i from requester i.
REQ-008 Port rel  input  N_REQ  one-cycle release pulse, bit i from requester i.
REQ-009 Port pat  input  N_REQ*N_LED  requester i pattern in bits [i*N_LED +: N_LED].
REQ-010 Port gnt  output  N_REQ  registered one-hot grant, all-zero when no owner.
REQ-011 Port busy  output  1  high while in state GRANT.
REQ-012 Port leds  output  N_LED  registered LED drive, feeds SB_IO D_OUT_0 at top level.
REQ-013 Port timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-014 FSM states SHALL be IDLE, GRANT, GAP; reset state IDLE.
REQ-015 A free-running counter of N_LED+LOG2DELAY bits SHALL increment every cycle in all states, wrapping to 0.
REQ-016 In IDLE, leds SHALL be registered as g = c ^ (c >> 1), c = counter >> LOG2DELAY (1-cycle latency).
REQ-017 In IDLE with req != 0, the arbiter SHALL pick the first set bit searching ptr, ptr+1, ... mod N_REQ, set gnt to that one-hot, latch owner, clear hold count, enter GRANT next cycle.
REQ-018 In IDLE with req == 0, gnt SHALL stay 0 and state stay IDLE.
REQ-019 In GRANT, leds SHALL be registered from pat slice of owner every cycle (1-cycle latency); other slices ignored.
REQ-020 In GRANT, hold count SHALL increment each cycle; grant ends when rel[owner]=1, or req[owner]=0, or hold count reaches MAX_HOLD-1.
REQ-021 Grant end SHALL move to GAP: gnt=0, busy=0, ptr=(owner+1) mod N_REQ.
REQ-022 timeout SHALL pulse for exactly the cycle entering GAP, only when the end cause is MAX_HOLD alone; release or req drop in the same cycle as MAX_HOLD suppresses timeout.
REQ-023 rel bits of non-owners SHALL be ignored in all states; rel in IDLE or GAP has no effect.
REQ-024 In GAP, leds SHALL be 0 for exactly one cycle; next state IDLE unconditionally.
REQ-025 Requests arriving in GRANT or GAP SHALL wait; no request is dropped while its req stays high.
REQ-026 Owner change to pat during GRANT SHALL appear on leds the next cycle.
REQ-027 Worst-case wait for a continuously asserted req SHALL be bounded by (N_REQ-1)*(MAX_HOLD+2)+2 cycles.

Reset
REQ-028 resetn low SHALL immediately force: state IDLE, gnt=0, busy=0, leds=0, timeout=0, ptr=0, hold count=0, counter=0.
REQ-029 Reset mid-GRANT SHALL drop the grant with no timeout pulse; after release, first arbitration starts from ptr=0.
REQ-030 First edge after resetn rises SHALL behave as IDLE with counter=0.

Verification (N_REQ=4, N_LED=5, LOG2DELAY=2, MAX_HOLD=8)
REQ-031 No req for 40 cycles -> leds steps 0,1,3,2,6,7,5,4,... changing every 4 cycles; gnt=0.
REQ-032 req=0b0110 from IDLE at ptr=0 -> gnt=0b0010 next cycle; rel[1] pulse -> GAP (leds=0, gnt=0), then gnt=0b0100 two cycles later.
REQ-033 req[0] held, pat[0]=5'h15, no rel -> leds=5'h15 one cycle after grant; timeout pulse after 8 GRANT cycles; gnt[0] returns after GAP+IDLE.
REQ-034 rel[0] and MAX_HOLD in same cycle -> GAP entered, timeout stays 0.
REQ-035 resetn low during GRANT owner 2 -> gnt=0, leds=0 asynchronously; after release with req=0b1111 -> gnt=0b0001.
REQ-036 All four req held 100 cycles -> grants rotate 0,1,2,3,0; no requester waits over 42 cycles.
